// File: rtl/tatsujin_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tatsujin_pkg
// Brief    : Shared screen geometry, colour constants and plotter state type.
// Revision : 1.0 - initial release
// ============================================================================
package tatsujin_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] COL_BLACK = 3'b000;
    localparam logic [COLOUR_W-1:0] COL_RED   = 3'b100;
    localparam logic [COLOUR_W-1:0] COL_BLUE  = 3'b001;
    localparam logic [COLOUR_W-1:0] COL_WHITE = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLIP = 2'd1,
        DRAW = 2'd2,
        DONE = 2'd3
    } rp_state_t;

endpackage
`default_nettype wire

// File: rtl/rect_plotter.sv
`default_nettype none
// ============================================================================
// Module   : rect_plotter
// Brief    : Clips a filled-rectangle command to the screen and streams one
//            pixel per clock to the VGA adapter in raster order.
// Revision : 1.0 - initial release
// ============================================================================
module rect_plotter
    import tatsujin_pkg::*;
(
    input  logic                clock,
    input  logic                resetn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [X_W-1:0]      req_x,
    input  logic [Y_W-1:0]      req_y,
    input  logic [X_W-1:0]      req_w,
    input  logic [Y_W-1:0]      req_h,
    input  logic [COLOUR_W-1:0] req_colour,
    input  logic                req_clear,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot
);

    localparam logic [X_W-1:0] c_x_last = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] c_y_last = Y_W'(SCREEN_H - 1);
    localparam logic [X_W-1:0] c_full_w = X_W'(SCREEN_W);
    localparam logic [Y_W-1:0] c_full_h = Y_W'(SCREEN_H);

    rp_state_t           r_state;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;
    logic                r_plot;
    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
    logic [COLOUR_W-1:0] r_colour;
    logic [X_W-1:0]      r_x0;
    logic [Y_W-1:0]      r_y0;
    logic [X_W-1:0]      r_w;
    logic [Y_W-1:0]      r_h;
    logic [COLOUR_W-1:0] r_fill;
    logic [X_W-1:0]      r_x_end;
    logic [Y_W-1:0]      r_y_end;

    logic [X_W:0]        w_x_sum;
    logic [Y_W:0]        w_y_sum;
    logic [X_W-1:0]      w_x_end;
    logic [Y_W-1:0]      w_y_end;
    logic                w_empty;

    // One extra bit on the far-edge sums so a large width saturates at the
    // screen edge instead of wrapping back into it.
    always_comb begin
        w_x_sum = {1'b0, r_x0} + {1'b0, r_w} - (X_W+1)'(1);
        w_y_sum = {1'b0, r_y0} + {1'b0, r_h} - (Y_W+1)'(1);
        w_x_end = (w_x_sum > {1'b0, c_x_last}) ? c_x_last : w_x_sum[X_W-1:0];
        w_y_end = (w_y_sum > {1'b0, c_y_last}) ? c_y_last : w_y_sum[Y_W-1:0];
        w_empty = (r_w == '0) || (r_h == '0) || (r_x0 > c_x_last) || (r_y0 > c_y_last);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_plot   <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_x0     <= '0;
            r_y0     <= '0;
            r_w      <= '0;
            r_h      <= '0;
            r_fill   <= '0;
            r_x_end  <= '0;
            r_y_end  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid && r_ready) begin
                        r_x0    <= req_clear ? '0       : req_x;
                        r_y0    <= req_clear ? '0       : req_y;
                        r_w     <= req_clear ? c_full_w : req_w;
                        r_h     <= req_clear ? c_full_h : req_h;
                        r_fill  <= req_colour;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= CLIP;
                    end
                end
                CLIP: begin
                    if (abort) begin
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_empty) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_x_end  <= w_x_end;
                        r_y_end  <= w_y_end;
                        r_x      <= r_x0;
                        r_y      <= r_y0;
                        r_colour <= r_fill;
                        r_plot   <= 1'b1;
                        r_state  <= DRAW;
                    end
                end
                DRAW: begin
                    // The output x/y registers double as the raster counters.
                    if (abort) begin
                        r_plot  <= 1'b0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_x == r_x_end) begin
                        if (r_y == r_y_end) begin
                            r_plot  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_x <= r_x0;
                            r_y <= r_y + Y_W'(1);
                        end
                    end else begin
                        r_x <= r_x + X_W'(1);
                    end
                end
                DONE: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_plot  <= 1'b0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign plot      = r_plot;
    assign x         = r_x;
    assign y         = r_y;
    assign colour    = r_colour;

endmodule
`default_nettype wire

// File: tb/tb_rect_plotter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rect_plotter
// Brief    : Self-checking bench for rect_plotter against a pixel-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rect_plotter;
    import tatsujin_pkg::*;

    logic                clock = 1'b0;
    logic                resetn;
    logic                req_valid;
    logic                req_ready;
    logic [X_W-1:0]      req_x;
    logic [Y_W-1:0]      req_y;
    logic [X_W-1:0]      req_w;
    logic [Y_W-1:0]      req_h;
    logic [COLOUR_W-1:0] req_colour;
    logic                req_clear;
    logic                abort;
    logic                busy;
    logic                done;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    rect_plotter dut (
        .clock      (clock),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_w      (req_w),
        .req_h      (req_h),
        .req_colour (req_colour),
        .req_clear  (req_clear),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv)
            $display("FAIL %s: got %0h expected %0h", tag, act, expv);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] pix_now();
        return {14'd0, x, y, colour};
    endfunction

    // Reference: enumerate the visible pixels of the command row by row.
    task automatic model_push(input int cx, input int cy, input int cw, input int ch,
                              input int ccol, input bit cclr, output int n);
        int x0 = cclr ? 0 : cx;
        int y0 = cclr ? 0 : cy;
        int w  = cclr ? SCREEN_W : cw;
        int h  = cclr ? SCREEN_H : ch;
        int xe, ye;
        n = 0;
        if (w > 0 && h > 0 && x0 < SCREEN_W && y0 < SCREEN_H) begin
            xe = (x0 + w - 1 < SCREEN_W) ? x0 + w - 1 : SCREEN_W - 1;
            ye = (y0 + h - 1 < SCREEN_H) ? y0 + h - 1 : SCREEN_H - 1;
            for (int yy = y0; yy <= ye; yy++)
                for (int xx = x0; xx <= xe; xx++) begin
                    exp_q.push_back(32'((xx << 10) | (yy << 3) | (ccol & 7)));
                    n++;
                end
        end
    endtask

    task automatic drive_cmd(input int cx, input int cy, input int cw, input int ch,
                             input int ccol, input bit cclr);
        req_x      = X_W'(cx);
        req_y      = Y_W'(cy);
        req_w      = X_W'(cw);
        req_h      = Y_W'(ch);
        req_colour = COLOUR_W'(ccol);
        req_clear  = cclr;
    endtask

    task automatic run_cmd(input int cx, input int cy, input int cw, input int ch,
                           input int ccol, input bit cclr, input bit abort_acc);
        int npix, cyc, got, first_plot, done_cyc, busy_cnt;
        logic [31:0] last_pix = '0;
        exp_q.delete();
        model_push(cx, cy, cw, ch, ccol, cclr, npix);
        @(negedge clock);
        drive_cmd(cx, cy, cw, ch, ccol, cclr);
        req_valid = 1'b1;
        abort     = abort_acc;
        cyc = 0;
        while (!req_ready && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        check("accept_ready", req_ready, 1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        abort     = 1'b0;
        cyc = 0; got = 0; first_plot = -1; done_cyc = -1; busy_cnt = 0;
        while (done_cyc < 0 && cyc < npix + 20) begin
            @(negedge clock);
            cyc++;
            if (busy) busy_cnt++;
            if (plot) begin
                if (exp_q.size() == 0) check("extra_plot", got + 1, npix);
                else check("pixel", pix_now(), exp_q.pop_front());
                if (first_plot < 0) first_plot = cyc;
                last_pix = pix_now();
                got++;
            end
            if (done) done_cyc = cyc;
        end
        check("done_seen", done_cyc >= 0, 1);
        check("pix_count", got, npix);
        check("done_cycle", done_cyc, npix + 2);
        check("busy_cycles", busy_cnt, npix + 2);
        if (npix > 0) begin
            check("first_plot_lat", first_plot, 2);
            check("hold_after_draw", pix_now(), last_pix);
        end
        @(negedge clock);
        check("ready_after_done", req_ready, 1);
        check("done_single", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int na, nb, n4, cyc, got, dones, last_a, first_b, n_done;
        resetn = 1'b0; req_valid = 1'b0; abort = 1'b0;
        drive_cmd(0, 0, 0, 0, 0, 1'b0);
        repeat (3) @(negedge clock);
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_plot", plot, 0);
        check("rst_xyc", pix_now(), 0);
        resetn = 1'b1;
        @(negedge clock);

        run_cmd(10, 20, 3, 2, 3'b100, 1'b0, 1'b0);
        run_cmd(158, 118, 5, 5, 3'b011, 1'b0, 1'b0);
        run_cmd(40, 40, 0, 5, 3'b111, 1'b0, 1'b0);
        run_cmd(160, 10, 4, 4, 3'b111, 1'b0, 1'b0);
        run_cmd(10, 120, 4, 4, 3'b001, 1'b0, 1'b0);
        run_cmd(150, 3, 255, 2, 3'b101, 1'b0, 1'b0);
        run_cmd(5, 100, 2, 127, 3'b110, 1'b0, 1'b0);
        run_cmd(7, 9, 2, 2, 3'b010, 1'b0, 1'b1);
        run_cmd($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 255),
                $urandom_range(0, 127), COL_BLACK, 1'b1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            if (i % 6 == 0)
                run_cmd($urandom_range(0, 170), $urandom_range(0, 127), $urandom_range(0, 255),
                        $urandom_range(0, 3), $urandom_range(0, 7), 1'b0, 1'b0);
            else
                run_cmd($urandom_range(0, 165), $urandom_range(0, 125), $urandom_range(0, 14),
                        $urandom_range(0, 10), $urandom_range(0, 7), 1'b0, 1'b0);
        end

        // Two back-to-back commands with req_valid held high throughout.
        exp_q.delete();
        model_push(20, 30, 3, 2, 3'b010, 1'b0, na);
        model_push(70, 5, 2, 3, 3'b111, 1'b0, nb);
        @(negedge clock);
        drive_cmd(20, 30, 3, 2, 3'b010, 1'b0);
        req_valid = 1'b1;
        @(posedge clock);
        #1;
        drive_cmd(70, 5, 2, 3, 3'b111, 1'b0);
        cyc = 0; got = 0; dones = 0; last_a = -1; first_b = -1;
        while (dones < 2 && cyc < 100) begin
            @(negedge clock);
            cyc++;
            if (plot) begin
                if (exp_q.size() == 0) check("hs_extra", got + 1, na + nb);
                else check("hs_pixel", pix_now(), exp_q.pop_front());
                got++;
                if (got == na) last_a = cyc;
                if (got == na + 1) first_b = cyc;
            end
            if (done) dones++;
            if (dones == 1 && req_ready && req_valid) begin
                @(posedge clock);
                #1;
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        check("hs_dones", dones, 2);
        check("hs_pix_count", got, na + nb);
        check("hs_gap", first_b - last_a, 4);

        // Abort on the third plot of a 4x4 rectangle.
        exp_q.delete();
        model_push(30, 40, 4, 4, 3'b101, 1'b0, n4);
        @(negedge clock);
        drive_cmd(30, 40, 4, 4, 3'b101, 1'b0);
        req_valid = 1'b1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        cyc = 0; got = 0;
        while (got < 3 && cyc < 20) begin
            @(negedge clock);
            cyc++;
            if (plot) begin
                check("abort_pixel", pix_now(), exp_q.pop_front());
                got++;
            end
        end
        check("abort_reached", got, 3);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_plot", plot, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", req_ready, 1);
        check("abort_done", done, 0);
        n_done = 0;
        repeat (6) begin
            @(negedge clock);
            if (done || plot) n_done++;
        end
        check("abort_quiet", n_done, 0);

        // Asynchronous reset in the middle of a draw.
        @(negedge clock);
        drive_cmd(50, 60, 5, 5, 3'b111, 1'b0);
        req_valid = 1'b1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        repeat (4) @(negedge clock);
        check("rst_mid_plotting", plot, 1);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_mid_plot", plot, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_xy", {x, y}, 0);
        check("rst_mid_ready", req_ready, 1);
        @(negedge clock);
        resetn = 1'b1;
        run_cmd(0, 0, 2, 2, 3'b001, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
